fetch_sequencer: RTL and testbench

// - Controls the instruction-fetch path: owns the PC and issues one instruction-memory

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_skid_buf.sv | 43 ++++
 rtl/fetch_sequencer.sv | 153 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch sequencer and its skid buffer.
package fetch_pkg;

    localparam int ADDR_W  = 24;
    localparam int INSTR_W = 24;
    localparam int PC_STEP = 4;
    localparam logic [23:0] RESET_PC = 24'h000000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry parking slot for a fetched {instr, pc} pair that decode could not take yet.
module fetch_skid_buf #(
    parameter int ADDR_W  = fetch_pkg::ADDR_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               load_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_q;

    // Flush wins over load so a redirect can never leave a stale entry behind.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (pop_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control: owns the PC, keeps one memory request in flight and
// feeds the IR/valid/PC tuple to decode, absorbing stalls, redirects and wait-states.
module fetch_sequencer #(
    parameter int              ADDR_W   = fetch_pkg::ADDR_W,
    parameter int              INSTR_W  = fetch_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(fetch_pkg::RESET_PC),
    parameter int              PC_STEP  = fetch_pkg::PC_STEP
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               branch_taken_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    output logic               mem_req_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic               mem_ready_i,
    input  logic [INSTR_W-1:0] mem_rdata_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    output logic               instr_valid_o,
    output logic [ADDR_W-1:0]  next_pc_o
);
    import fetch_pkg::*;

    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  drainAddr_q, drainAddr_d;
    logic [ADDR_W-1:0]  instrPc_q, instrPc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;

    logic               accept;
    logic               skidLoad, skidPop, skidFlush, skidValid;
    logic [INSTR_W-1:0] skidInstr;
    logic [ADDR_W-1:0]  skidPc;

    assign accept = !stall_i || !valid_q;

    fetch_skid_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .CLK     (CLK),
        .rst     (rst),
        .load_i  (skidLoad),
        .pop_i   (skidPop),
        .flush_i (skidFlush),
        .instr_i (mem_rdata_i),
        .pc_i    (pc_q),
        .valid_o (skidValid),
        .instr_o (skidInstr),
        .pc_o    (skidPc)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drainAddr_d = drainAddr_q;
        instr_d     = instr_q;
        instrPc_d   = instrPc_q;
        valid_d     = valid_q;
        skidLoad    = 1'b0;
        skidPop     = 1'b0;
        skidFlush   = 1'b0;
        mem_req_o   = 1'b0;
        mem_addr_o  = pc_q;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    pc_d = pc_q + STEP;
                    if (accept) begin
                        instr_d   = mem_rdata_i;
                        instrPc_d = pc_q;
                        valid_d   = 1'b1;
                    end else begin
                        skidLoad = 1'b1;
                        state_d  = HOLD;
                    end
                end else if (accept) begin
                    // Decode consumed the IR and nothing new arrived: present a bubble.
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (!skidValid) begin
                    state_d = FETCH;
                end else if (accept) begin
                    instr_d   = skidInstr;
                    instrPc_d = skidPc;
                    valid_d   = 1'b1;
                    skidPop   = 1'b1;
                    state_d   = FETCH;
                end
            end
            DRAIN: begin
                mem_req_o  = 1'b1;
                mem_addr_o = drainAddr_q;
                if (mem_ready_i) begin
                    state_d = FETCH;
                end
            end
        endcase

        // A redirect overrides every decision above, including a same-cycle IR load.
        if (branch_taken_i) begin
            valid_d   = 1'b0;
            instr_d   = instr_q;
            instrPc_d = instrPc_q;
            skidLoad  = 1'b0;
            skidPop   = 1'b0;
            skidFlush = 1'b1;
            pc_d      = branch_target_i & ALIGN_MASK;
            if (state_q == FETCH && !mem_ready_i) begin
                drainAddr_d = pc_q;
                state_d     = DRAIN;
            end else if (state_q == DRAIN && !mem_ready_i) begin
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            drainAddr_q <= RESET_PC;
            instr_q     <= '0;
            instrPc_q   <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drainAddr_q <= drainAddr_d;
            instr_q     <= instr_d;
            instrPc_q   <= instrPc_d;
            valid_q     <= valid_d;
        end
    end

    assign instr_o       = instr_q;
    assign instr_pc_o    = instrPc_q;
    assign instr_valid_o = valid_q;
    assign next_pc_o     = instrPc_q + STEP;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory returns {8'hA5, addr[15:0]} for every address.
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_taken_i;
    logic [23:0] branch_target_i;
    logic        mem_req_o;
    logic [23:0] mem_addr_o;
    logic        mem_ready_i;
    logic [23:0] mem_rdata_i;
    logic [23:0] instr_o;
    logic [23:0] instr_pc_o;
    logic        instr_valid_o;
    logic [23:0] next_pc_o;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    assign mem_rdata_i = {8'hA5, mem_addr_o[15:0]};

    fetch_sequencer dut (
        .CLK             (CLK),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_ready_i     (mem_ready_i),
        .mem_rdata_i     (mem_rdata_i),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .instr_valid_o   (instr_valid_o),
        .next_pc_o       (next_pc_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic stall, input logic branch, input logic [23:0] target, input logic ready);
        stall_i         = stall;
        branch_taken_i  = branch;
        branch_target_i = target;
        mem_ready_i     = ready;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
        #1;
        checkOutput("rst_req",   32'(mem_req_o),     32'h0);
        checkOutput("rst_valid", 32'(instr_valid_o), 32'h0);
        checkOutput("rst_instr", 32'(instr_o),       32'h0);
        checkOutput("rst_ipc",   32'(instr_pc_o),    32'h0);
        checkOutput("rst_npc",   32'(next_pc_o),     32'h4);
        #2 rst = 1'b1;

        // Zero-wait memory
        tick();
        checkOutput("zw_req0",   32'(mem_req_o),     32'h1);
        checkOutput("zw_addr0",  32'(mem_addr_o),    32'h0);
        checkOutput("zw_valid0", 32'(instr_valid_o), 32'h0);
        tick();
        checkOutput("zw_addr1",  32'(mem_addr_o),    32'h4);
        checkOutput("zw_valid1", 32'(instr_valid_o), 32'h1);
        checkOutput("zw_ipc1",   32'(instr_pc_o),    32'h0);
        checkOutput("zw_instr1", 32'(instr_o),       32'hA50000);
        checkOutput("zw_npc1",   32'(next_pc_o),     32'h4);
        tick();
        checkOutput("zw_addr2",  32'(mem_addr_o),    32'h8);
        checkOutput("zw_ipc2",   32'(instr_pc_o),    32'h4);
        tick();
        checkOutput("zw_ipc3",   32'(instr_pc_o),    32'h8);
        checkOutput("zw_addr3",  32'(mem_addr_o),    32'hC);
        tick();
        checkOutput("zw_ipc4",   32'(instr_pc_o),    32'hC);
        checkOutput("zw_addr4",  32'(mem_addr_o),    32'h10);

        // Three wait-states on 0x10
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("ws_addr%0d", i), 32'(mem_addr_o), 32'h10);
            checkOutput($sformatf("ws_req%0d", i),  32'(mem_req_o),  32'h1);
        end
        checkOutput("ws_bubble", 32'(instr_valid_o), 32'h0);
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
        tick();
        checkOutput("ws_ipc",   32'(instr_pc_o),    32'h10);
        checkOutput("ws_instr", 32'(instr_o),       32'hA50010);
        checkOutput("ws_valid", 32'(instr_valid_o), 32'h1);
        checkOutput("ws_addr",  32'(mem_addr_o),    32'h14);
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
        tick();
        checkOutput("ws_nodup", 32'(instr_valid_o), 32'h0);

        // Run up to IR at 0x20, then stall for two cycles
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("st_pre_ipc",  32'(instr_pc_o), 32'h20);
        checkOutput("st_pre_addr", 32'(mem_addr_o), 32'h24);
        applyStimulus(1'b1, 1'b0, 24'h0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput($sformatf("st_req%0d", i),   32'(mem_req_o),     32'h0);
            checkOutput($sformatf("st_ipc%0d", i),   32'(instr_pc_o),    32'h20);
            checkOutput($sformatf("st_instr%0d", i), 32'(instr_o),       32'hA50020);
            checkOutput($sformatf("st_valid%0d", i), 32'(instr_valid_o), 32'h1);
        end
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
        tick();
        checkOutput("st_rel_ipc",   32'(instr_pc_o), 32'h24);
        checkOutput("st_rel_instr", 32'(instr_o),    32'hA50024);
        checkOutput("st_rel_addr",  32'(mem_addr_o), 32'h28);
        tick();
        checkOutput("st_rel_ipc2",  32'(instr_pc_o), 32'h28);

        // Branch to 0x103 while 0x40 is pending
        for (int i = 0; i < 5; i++) tick();
        checkOutput("br_pre_addr", 32'(mem_addr_o), 32'h40);
        checkOutput("br_pre_ipc",  32'(instr_pc_o), 32'h3C);
        applyStimulus(1'b0, 1'b1, 24'h000103, 1'b0);
        tick();
        checkOutput("br_drain_req",   32'(mem_req_o),     32'h1);
        checkOutput("br_drain_addr",  32'(mem_addr_o),    32'h40);
        checkOutput("br_drain_valid", 32'(instr_valid_o), 32'h0);
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
        tick();
        checkOutput("br_drain_addr2", 32'(mem_addr_o), 32'h40);
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
        tick();
        checkOutput("br_discard_valid", 32'(instr_valid_o), 32'h0);
        checkOutput("br_discard_ipc",   32'(instr_pc_o),    32'h3C);
        checkOutput("br_target_addr",   32'(mem_addr_o),    32'h100);
        tick();
        checkOutput("br_tgt_ipc",   32'(instr_pc_o),    32'h100);
        checkOutput("br_tgt_instr", 32'(instr_o),       32'hA50100);
        checkOutput("br_tgt_valid", 32'(instr_valid_o), 32'h1);

        // Branch together with stall while HOLD has a parked entry
        applyStimulus(1'b1, 1'b0, 24'h0, 1'b1);
        tick();
        checkOutput("hb_hold_req", 32'(mem_req_o), 32'h0);
        applyStimulus(1'b1, 1'b1, 24'h000200, 1'b1);
        tick();
        checkOutput("hb_valid", 32'(instr_valid_o), 32'h0);
        checkOutput("hb_req",   32'(mem_req_o),     32'h1);
        checkOutput("hb_addr",  32'(mem_addr_o),    32'h200);
        applyStimulus(1'b1, 1'b0, 24'h0, 1'b1);
        tick();
        checkOutput("hb_ipc",   32'(instr_pc_o),    32'h200);
        checkOutput("hb_instr", 32'(instr_o),       32'hA50200);

        // PC wrap
        applyStimulus(1'b0, 1'b1, 24'hFFFFFC, 1'b1);
        tick();
        checkOutput("wr_addr0",  32'(mem_addr_o),    32'hFFFFFC);
        checkOutput("wr_valid0", 32'(instr_valid_o), 32'h0);
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
        tick();
        checkOutput("wr_ipc",   32'(instr_pc_o), 32'hFFFFFC);
        checkOutput("wr_instr", 32'(instr_o),    32'hA5FFFC);
        checkOutput("wr_addr1", 32'(mem_addr_o), 32'h000000);
        checkOutput("wr_npc",   32'(next_pc_o),  32'h000000);
        tick();
        checkOutput("wr_ipc2",  32'(instr_pc_o), 32'h000000);

        // Reset mid-request
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("mr_req",   32'(mem_req_o),     32'h0);
        checkOutput("mr_valid", 32'(instr_valid_o), 32'h0);
        checkOutput("mr_instr", 32'(instr_o),       32'h0);
        checkOutput("mr_ipc",   32'(instr_pc_o),    32'h0);
        checkOutput("mr_npc",   32'(next_pc_o),     32'h4);
        checkOutput("mr_addr",  32'(mem_addr_o),    32'h0);
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
        tick();
        checkOutput("mr_hold_req", 32'(mem_req_o), 32'h0);
        rst = 1'b1;
        tick();
        checkOutput("mr_idle_valid", 32'(instr_valid_o), 32'h0);
        checkOutput("mr_fetch_req",  32'(mem_req_o),     32'h1);
        checkOutput("mr_fetch_addr", 32'(mem_addr_o),    32'h0);
        tick();
        checkOutput("mr_first_ipc",   32'(instr_pc_o),    32'h0);
        checkOutput("mr_first_valid", 32'(instr_valid_o), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
